rram_train_seq: RTL and testbench
=================================

RRAM_TRAIN_SEQ -- requirements
Module: rram_train_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter SETTLE, default 8: cycles each forward layer phase is held (legal range 1..255).
REQ-003 Parameter BACK_LEN, default 16: cycles the back-propagation phase is held (1..255).
REQ-004 Parameter SET_LEN, default 4: cycles the weight-set phase is held (1..255).
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port rst_n, input, 1: synchronous active-low reset.
REQ-007 Port s_valid, input, 1: sample offered.
REQ-008 Port s_ready, output, 1: sample buffer can accept.
REQ-009 Port s_data, input, 4: input feature vector, bit 3 = layer-1 row 11.
REQ-010 Port s_label, input, 3: one-hot target class, bit 2 = class 3.
REQ-011 Port train_en, input, 1: 1 = full train cycle, 0 = inference only; sampled with the sample.
REQ-012 Port dwl, output, 12: word-line enables to the RRAM array (11:8 layer 1, 7:4 layer 2, 3:0 layer 3).
REQ-013 Port dsl, output, 12: source-line drive bits, same layer grouping.
REQ-014 Port dbl, output, 12: bit-line drive bits, same layer grouping.
REQ-015 Port dset, output, 1: weight-set enable.
REQ-016 Port dback, output, 1: back-propagation enable.
REQ-017 Port dlabel, output, 3: target label to the error calculators.
REQ-018 Port busy, output, 1: high in any state other than IDLE.
REQ-019 Port done, output, 1: one-cycle pulse at end of each sample.
REQ-020 Port sample_cnt, output, 8: completed-sample counter.

Function
REQ-021 Sample buffer SHALL be a 2-entry FIFO of {train_en, s_label, s_data}; s_ready = not full, registered; a push occurs on an edge where s_valid and s_ready are both 1.
REQ-022 FSM states SHALL be IDLE, FWD1, FWD2, FWD3, BACK, SET, DONE.
REQ-023 In IDLE with FIFO non-empty, the FSM SHALL pop the head entry and enter FWD1 at the next edge; an empty FIFO keeps IDLE.
REQ-024 A push and a pop on the same edge SHALL both take effect; occupancy is unchanged.
REQ-025 Each FWDk SHALL last exactly SETTLE cycles, BACK exactly BACK_LEN, SET exactly SET_LEN, and DONE exactly 1; transitions: FWD1->FWD2->FWD3->BACK->SET->DONE->IDLE.
REQ-026 When the popped train_en is 0, FWD3 SHALL go directly to DONE, skipping BACK and SET.
REQ-027 A down-counter loaded with (length-1) on phase entry SHALL set the phase length; the phase exits at the edge after the count reaches 0.
REQ-028 All array outputs SHALL be registered and change only on state-entry edges.
REQ-029 FWD1: dwl[11:8]=4'hF, dsl[11:8]=popped s_data, all other dwl/dsl bits 0, dbl=0.
REQ-030 FWD2: dwl[7:4]=4'hF, dsl[7:4]=4'hF, all other bits 0, dbl=0. FWD3: the same pattern on the 3:0 groups.
REQ-031 BACK: dback=1, dwl=12'hFFF, dsl=0, dbl=0, dset=0.
REQ-032 SET: dset=1, dback=0, dwl=12'hFFF, dbl=12'hFFF, dsl=0.
REQ-033 IDLE and DONE: dwl=dsl=dbl=0, dset=dback=0.
REQ-034 dlabel SHALL hold the popped label from FWD1 entry through DONE, and 3'b000 in IDLE.
REQ-035 done SHALL be 1 only during DONE; sample_cnt increments by 1 on DONE entry and wraps 255->0.
REQ-036 dset and dback SHALL never be 1 in the same cycle.

Reset
REQ-037 On a clock edge with rst_n=0: FSM returns to IDLE, FIFO empties, counters clear, and all outputs are 0 (s_ready=1 from the following cycle), including mid-phase.
REQ-038 After rst_n returns to 1, no array output SHALL be asserted until a new sample is pushed.

Verification (SETTLE=2, BACK_LEN=3, SET_LEN=2)
REQ-039 Train sample: push s_data=4'b1010, s_label=3'b010, train_en=1 at edge 0 -> FWD1 over cycles 1-2 (dsl[11:8]=1010, dlabel=010), FWD2 3-4, FWD3 5-6, BACK 7-9, SET 10-11, done=1 in cycle 12, IDLE at 13, sample_cnt=1.
REQ-040 Inference sample with train_en=0 at edge 0 -> FWD3 ends at cycle 6, done in cycle 7, dset and dback never 1.
REQ-041 Three back-to-back pushes -> s_ready drops after 2 are buffered; the third is accepted after the first pop; three done pulses 13 cycles apart.
REQ-042 rst_n=0 during BACK (cycle 8) -> all outputs 0 at the next edge, busy=0, FIFO empty, sample_cnt=0.
REQ-043 Run 256 samples -> sample_cnt wraps to 0 after the 256th done.
REQ-044 Assertion across all tests: dset & dback is never 1, and exactly one wl group is non-zero in any FWD state.

Source files
------------

// File: rtl/rram_train_seq.sv
// Sequencer for a 3-layer RRAM training array. Samples are buffered in a 2-entry
// FIFO, then driven through forward, back-propagation and weight-set phases.
module rram_train_seq #(
  parameter int SETTLE   = 8,
  parameter int BACK_LEN = 16,
  parameter int SET_LEN  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [3:0]  s_data,
  input  logic [2:0]  s_label,
  input  logic        train_en,
  output logic [11:0] dwl,
  output logic [11:0] dsl,
  output logic [11:0] dbl,
  output logic        dset,
  output logic        dback,
  output logic [2:0]  dlabel,
  output logic        busy,
  output logic        done,
  output logic [7:0]  sample_cnt
);

  localparam logic [7:0] SETTLE_M1 = 8'(SETTLE - 1);
  localparam logic [7:0] BACK_M1   = 8'(BACK_LEN - 1);
  localparam logic [7:0] SET_M1    = 8'(SET_LEN - 1);

  typedef enum logic [2:0] {IDLE, FWD1, FWD2, FWD3, BACK, SET, DONE} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       train_q;

  logic [7:0] fifo_mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] fifo_cnt;
  logic [1:0] fifo_cnt_nxt;
  logic       push;
  logic       pop;
  logic [7:0] head;

  assign push = s_valid & s_ready;
  assign pop  = (state == IDLE) && (fifo_cnt != 2'd0);
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    case ({push, pop})
      2'b10:   fifo_cnt_nxt = fifo_cnt + 2'd1;
      2'b01:   fifo_cnt_nxt = fifo_cnt - 2'd1;
      default: fifo_cnt_nxt = fifo_cnt;
    endcase
  end

  // Entry layout: {train_en, label[2:0], data[3:0]}; storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {train_en, s_label, s_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      s_ready  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt_nxt;
      s_ready  <= (fifo_cnt_nxt != 2'd2);
    end
  end

  // Array drive patterns are loaded only on the edge that enters a state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      train_q    <= 1'b0;
      dwl        <= 12'h000;
      dsl        <= 12'h000;
      dbl        <= 12'h000;
      dset       <= 1'b0;
      dback      <= 1'b0;
      dlabel     <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      sample_cnt <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state   <= FWD1;
            cnt     <= SETTLE_M1;
            train_q <= head[7];
            dlabel  <= head[6:4];
            dwl     <= 12'hF00;
            dsl     <= {head[3:0], 8'h00};
            dbl     <= 12'h000;
            busy    <= 1'b1;
          end
        end
        FWD1: begin
          if (cnt == 8'd0) begin
            state <= FWD2;
            cnt   <= SETTLE_M1;
            dwl   <= 12'h0F0;
            dsl   <= 12'h0F0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        FWD2: begin
          if (cnt == 8'd0) begin
            state <= FWD3;
            cnt   <= SETTLE_M1;
            dwl   <= 12'h00F;
            dsl   <= 12'h00F;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        FWD3: begin
          if (cnt == 8'd0) begin
            dsl <= 12'h000;
            if (train_q) begin
              state <= BACK;
              cnt   <= BACK_M1;
              dwl   <= 12'hFFF;
              dback <= 1'b1;
            end else begin
              state      <= DONE;
              dwl        <= 12'h000;
              done       <= 1'b1;
              sample_cnt <= sample_cnt + 8'd1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        BACK: begin
          if (cnt == 8'd0) begin
            state <= SET;
            cnt   <= SET_M1;
            dback <= 1'b0;
            dset  <= 1'b1;
            dbl   <= 12'hFFF;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SET: begin
          if (cnt == 8'd0) begin
            state      <= DONE;
            dset       <= 1'b0;
            dwl        <= 12'h000;
            dbl        <= 12'h000;
            done       <= 1'b1;
            sample_cnt <= sample_cnt + 8'd1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          state  <= IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          dlabel <= 3'b000;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rram_train_seq.sv
// Directed bench for rram_train_seq with a sample scoreboard and per-cycle invariants.
module tb_rram_train_seq;

  localparam int SETTLE   = 2;
  localparam int BACK_LEN = 3;
  localparam int SET_LEN  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [3:0]  s_data = 4'h0;
  logic [2:0]  s_label = 3'b000;
  logic        train_en = 1'b0;
  logic [11:0] dwl, dsl, dbl;
  logic        dset, dback, busy, done;
  logic [2:0]  dlabel;
  logic [7:0]  sample_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       tr;
    logic [2:0] lab;
    logic [3:0] dat;
  } samp_t;

  samp_t  sbq[$];
  longint done_q[$];
  longint last_acc_t;
  samp_t  cur;
  int     ph;
  int     grp;
  logic   saw;
  logic   in_sample = 1'b0;
  int     exp_cnt = 0;

  always #5 clk = ~clk;

  rram_train_seq #(.SETTLE(SETTLE), .BACK_LEN(BACK_LEN), .SET_LEN(SET_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_label(s_label), .train_en(train_en),
    .dwl(dwl), .dsl(dsl), .dbl(dbl), .dset(dset), .dback(dback),
    .dlabel(dlabel), .busy(busy), .done(done), .sample_cnt(sample_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Cycle (relative to FWD1 entry) at which done is high.
  function automatic int exp_dn(input logic tr);
    return tr ? 3*SETTLE + BACK_LEN + SET_LEN + 1 : 3*SETTLE + 1;
  endfunction

  // Expected {busy,done,dset,dback,dwl,dsl,dbl} in cycle k after the accepting edge 0.
  function automatic logic [39:0] exp_out(input int k, input logic tr, input logic [3:0] d);
    logic [11:0] wl, sl, bl;
    logic bs, dn, st, bk;
    int f3, bkend, stend;
    wl = '0; sl = '0; bl = '0; bs = 1'b0; dn = 1'b0; st = 1'b0; bk = 1'b0;
    f3 = 3*SETTLE; bkend = f3 + BACK_LEN; stend = bkend + SET_LEN;
    if (k >= 1) begin
      if (k <= SETTLE) begin wl = 12'hF00; sl = {d, 8'h00}; end
      else if (k <= 2*SETTLE) begin wl = 12'h0F0; sl = 12'h0F0; end
      else if (k <= f3) begin wl = 12'h00F; sl = 12'h00F; end
      else if (tr && k <= bkend) begin wl = 12'hFFF; bk = 1'b1; end
      else if (tr && k <= stend) begin wl = 12'hFFF; bl = 12'hFFF; st = 1'b1; end
      bs = (k <= exp_dn(tr));
      dn = (k == exp_dn(tr));
    end
    return {bs, dn, st, bk, wl, sl, bl};
  endfunction

  task automatic push(input logic tr, input logic [2:0] lab, input logic [3:0] dat);
    int w = 0;
    s_valid = 1'b1; train_en = tr; s_label = lab; s_data = dat;
    while (!s_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("push_ready", s_ready, 1'b1);
    @(posedge clk);
    last_acc_t = $time;
    sbq.push_back('{tr: tr, lab: lab, dat: dat});
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0 || in_sample) && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", (w < 5000), 1'b1);
  endtask

  // Scoreboard and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("dset_dback_excl", dset & dback, 1'b0);
      if (busy && !done && !dset && !dback) begin
        grp = int'(dwl[11:8] != 4'h0) + int'(dwl[7:4] != 4'h0) + int'(dwl[3:0] != 4'h0);
        check("fwd_one_wl_group", grp, 1);
      end
      if (!in_sample && dwl == 12'hF00) begin
        check("sb_nonempty", (sbq.size() > 0), 1'b1);
        if (sbq.size() > 0) cur = sbq.pop_front();
        else cur = '0;
        check("fwd1_dsl", dsl[11:8], cur.dat);
        check("fwd1_dlabel", dlabel, cur.lab);
        in_sample = 1'b1;
        ph = 0;
        saw = 1'b0;
      end
      if (in_sample) begin
        ph++;
        if (dset | dback) saw = 1'b1;
        if (done) begin
          check("sample_len", ph, exp_dn(cur.tr));
          check("back_set_seen", saw, cur.tr);
          check("done_dlabel", dlabel, cur.lab);
          exp_cnt = (exp_cnt + 1) % 256;
          check("sample_cnt", sample_cnt, exp_cnt);
          done_q.push_back($time);
          in_sample = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [39:0] ev;
    longint t_a, act;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {busy, done, dset, dback, dwl, dsl, dbl}, 40'h0);
    check("rst_dlabel", dlabel, 3'b000);
    check("rst_sample_cnt", sample_cnt, 8'd0);
    check("rst_ready_low", s_ready, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", s_ready, 1'b1);

    // Train sample, cycle-exact
    push(1'b1, 3'b010, 4'b1010);
    for (int k = 0; k <= 13; k++) begin
      @(negedge clk);
      ev = exp_out(k, 1'b1, 4'b1010);
      check($sformatf("train_k%0d", k), {busy, done, dset, dback, dwl, dsl, dbl}, ev);
      check($sformatf("train_lbl_k%0d", k), dlabel, (k >= 1 && k <= exp_dn(1'b1)) ? 3'b010 : 3'b000);
    end
    check("train_cnt", sample_cnt, 8'd1);

    // Inference sample, cycle-exact
    push(1'b0, 3'b100, 4'b0110);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      ev = exp_out(k, 1'b0, 4'b0110);
      check($sformatf("infer_k%0d", k), {busy, done, dset, dback, dwl, dsl, dbl}, ev);
    end
    check("infer_cnt", sample_cnt, 8'd2);
    wait_idle();

    // Back-to-back pushes: FIFO fills, fourth waits for a pop
    done_q.delete();
    push(1'b1, 3'b001, 4'h3);
    t_a = last_acc_t;
    push(1'b1, 3'b010, 4'h5);
    check("b2b_acc2", (last_acc_t - t_a) / 10, 1);
    push(1'b1, 3'b100, 4'h9);
    check("b2b_acc3", (last_acc_t - t_a) / 10, 2);
    check("b2b_full_ready", s_ready, 1'b0);
    push(1'b1, 3'b001, 4'hC);
    check("b2b_acc4", (last_acc_t - t_a) / 10, exp_dn(1'b1) + 3);
    wait_idle();
    check("b2b_done_count", done_q.size(), 4);
    for (int i = 1; i < 4; i++) begin
      if (i < done_q.size())
        check($sformatf("b2b_done_gap%0d", i), (done_q[i] - done_q[i-1]) / 10, exp_dn(1'b1) + 1);
    end
    check("b2b_cnt", sample_cnt, 8'd6);

    // Reset during BACK with a second sample still buffered
    push(1'b1, 3'b010, 4'hF);
    push(1'b0, 3'b001, 4'h1);
    repeat (8) @(negedge clk);
    check("pre_rst_back", dback, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_outputs", {busy, done, dset, dback, dwl, dsl, dbl}, 40'h0);
    check("mid_rst_dlabel", dlabel, 3'b000);
    check("mid_rst_cnt", sample_cnt, 8'd0);
    sbq.delete();
    in_sample = 1'b0;
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", s_ready, 1'b1);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || dset || dback || (dwl != 0) || (dsl != 0) || (dbl != 0) || done) act++;
    end
    check("post_rst_quiet", act, 0);
    check("post_rst_cnt", sample_cnt, 8'd0);

    // Counter wrap over 256 samples
    for (int i = 0; i < 256; i++) begin
      push(1'b0, 3'b001 << $urandom_range(0, 2), 4'($urandom));
      if (i == 254) begin
        wait_idle();
        check("wrap_255", sample_cnt, 8'd255);
      end
    end
    wait_idle();
    check("wrap_zero", sample_cnt, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
